// File: rtl/mux_pkg.sv
// mux_pkg: shared occupancy encoding and legal input-count range for the skid mux
package mux_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;
  localparam int NUM_IN_MIN = 2;
  localparam int NUM_IN_MAX = 16;
endpackage

// File: rtl/mux_n_to_1.sv
// mux_n_to_1: combinational N-way word selector, out-of-range select yields zero plus err
module mux_n_to_1 #(
  parameter int WIDTH = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        word,
  output logic                    err
);
  always_comb begin
    err = int'(sel) >= NUM_IN;
    word = err ? '0 : in_data[int'(sel)*WIDTH +: WIDTH];
  end
endmodule

// File: rtl/mux_n_to_1_skid.sv
// mux_n_to_1_skid: N-way word mux feeding a two-entry head/skid buffer with valid/ready
module mux_n_to_1_skid
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    sel_err,
  output logic                    out_valid,
  input  logic                    out_ready
);
  if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
    $error("mux_n_to_1_skid: NUM_IN out of range");
  end
  occ_t state, nxt;
  logic [WIDTH-1:0] head_d, skid_d, new_d;
  logic head_e, skid_e, new_e;
  logic acc, pop, ld_head, ld_skid, shift;
  mux_n_to_1 #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_sel (
    .in_data(in_data),
    .sel(sel),
    .word(new_d),
    .err(new_e)
  );
  assign in_ready = state != TWO;
  assign out_valid = state != EMPTY;
  assign out_data = head_d;
  assign sel_err = head_e;
  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  always_comb begin
    nxt = state;
    ld_head = 1'b0;
    ld_skid = 1'b0;
    shift = 1'b0;
    case (state)
      EMPTY: begin
        nxt = acc ? ONE : EMPTY;
        ld_head = acc;
      end
      ONE: begin
        nxt = (acc && !pop) ? TWO : (!acc && pop) ? EMPTY : ONE;
        ld_head = acc && pop;
        ld_skid = acc && !pop;
      end
      TWO: begin
        nxt = pop ? ONE : TWO;
        shift = pop;
      end
      default: nxt = EMPTY;
    endcase
    // flush drops the concurrent word too; the pop still counts as consumed
    if (flush) begin
      nxt = EMPTY;
      ld_head = 1'b0;
      ld_skid = 1'b0;
      shift = 1'b0;
    end
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= EMPTY;
      head_d <= '0;
      head_e <= 1'b0;
      skid_d <= '0;
      skid_e <= 1'b0;
    end else begin
      state <= nxt;
      if (ld_head) {head_d, head_e} <= {new_d, new_e};
      else if (shift) {head_d, head_e} <= {skid_d, skid_e};
      if (ld_skid) {skid_d, skid_e} <= {new_d, new_e};
    end
  end
endmodule

// File: tb/tb_mux_n_to_1_skid.sv
// tb_mux_n_to_1_skid: table vectors, corner sequences and random traffic vs a queue model
module tb_mux_n_to_1_skid;
  localparam int W = 32;
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic Rst, in_valid, out_ready, flush;
  logic [1:0] sel;
  logic [4*W-1:0] in_data;
  logic ir4, ov4, er4, ir3, ov3, er3;
  logic [W-1:0] od4, od3;
  mux_n_to_1_skid #(.WIDTH(W), .NUM_IN(4)) d4 (
    .Clk(Clk), .Rst(Rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(ir4), .flush(flush), .out_data(od4), .sel_err(er4),
    .out_valid(ov4), .out_ready(out_ready)
  );
  mux_n_to_1_skid #(.WIDTH(W), .NUM_IN(3)) d3 (
    .Clk(Clk), .Rst(Rst), .in_data(in_data[3*W-1:0]), .sel(sel), .in_valid(in_valid),
    .in_ready(ir3), .flush(flush), .out_data(od3), .sel_err(er3),
    .out_valid(ov3), .out_ready(out_ready)
  );
  typedef struct packed {logic [W-1:0] d; logic e;} ent_t;
  ent_t q4[$];
  ent_t q3[$];
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic iv, ordy, fl;
    logic [1:0] sel;
    logic ov, ir;
    logic [W-1:0] od;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic ent_t pick(input int n);
    ent_t r;
    r.e = int'(sel) >= n;
    r.d = r.e ? '0 : in_data[int'(sel)*W +: W];
    return r;
  endfunction

  task automatic advance();
    bit a4, p4, a3, p3;
    ent_t e4, e3;
    a4 = in_valid && q4.size() < 2;
    p4 = out_ready && q4.size() > 0;
    a3 = in_valid && q3.size() < 2;
    p3 = out_ready && q3.size() > 0;
    e4 = pick(4);
    e3 = pick(3);
    @(posedge Clk);
    #1;
    if (Rst || flush) begin
      q4.delete();
      q3.delete();
    end else begin
      if (p4) void'(q4.pop_front());
      if (a4) q4.push_back(e4);
      if (p3) void'(q3.pop_front());
      if (a3) q3.push_back(e3);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ov4"}, W'(ov4), W'(q4.size() > 0));
    chk({tag, ".ir4"}, W'(ir4), W'(q4.size() < 2));
    if (q4.size() > 0) begin
      chk({tag, ".od4"}, od4, q4[0].d);
      chk({tag, ".er4"}, W'(er4), W'(q4[0].e));
    end
    chk({tag, ".ov3"}, W'(ov3), W'(q3.size() > 0));
    chk({tag, ".ir3"}, W'(ir3), W'(q3.size() < 2));
    if (q3.size() > 0) begin
      chk({tag, ".od3"}, od3, q3[0].d);
      chk({tag, ".er3"}, W'(er3), W'(q3[0].e));
    end
  endtask

  initial begin
    tbl[0]  = '{1, 1, 0, 2'd0, 1, 1, 32'hA0};
    tbl[1]  = '{1, 1, 0, 2'd1, 1, 1, 32'hA1};
    tbl[2]  = '{1, 1, 0, 2'd2, 1, 1, 32'hA2};
    tbl[3]  = '{1, 1, 0, 2'd3, 1, 1, 32'hA3};
    tbl[4]  = '{1, 0, 0, 2'd0, 1, 0, 32'hA3};
    tbl[5]  = '{1, 0, 0, 2'd1, 1, 0, 32'hA3};
    tbl[6]  = '{1, 0, 0, 2'd1, 1, 0, 32'hA3};
    tbl[7]  = '{0, 1, 0, 2'd2, 1, 1, 32'hA0};
    tbl[8]  = '{0, 1, 0, 2'd2, 0, 1, 32'h0};
    tbl[9]  = '{1, 0, 0, 2'd2, 1, 1, 32'hA2};
    tbl[10] = '{1, 0, 0, 2'd3, 1, 0, 32'hA2};
    tbl[11] = '{1, 0, 1, 2'd1, 0, 1, 32'h0};
    tbl[12] = '{0, 1, 0, 2'd0, 0, 1, 32'h0};
    Rst = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'($urandom);
      out_ready = 1'($urandom);
      sel = 2'($urandom);
      in_data = {$urandom, $urandom, $urandom, $urandom};
      advance();
      check_all("rst");
      chk("rst.od4", od4, '0);
      chk("rst.er4", W'(er4), '0);
      chk("rst.od3", od3, '0);
      chk("rst.er3", W'(er3), '0);
    end
    Rst = 1'b0;
    in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    for (int i = 0; i < 13; i++) begin
      in_valid = tbl[i].iv;
      out_ready = tbl[i].ordy;
      flush = tbl[i].fl;
      sel = tbl[i].sel;
      advance();
      check_all($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.ov", i), W'(ov4), W'(tbl[i].ov));
      chk($sformatf("tbl%0d.ir", i), W'(ir4), W'(tbl[i].ir));
      if (tbl[i].ov) chk($sformatf("tbl%0d.od", i), od4, tbl[i].od);
    end
    flush = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    sel = 2'd3;
    advance();
    check_all("oor");
    chk("oor.od3", od3, '0);
    chk("oor.er3", W'(er3), 1);
    chk("oor.od4", od4, 32'hA3);
    sel = 2'd2;
    advance();
    check_all("oor2");
    chk("oor2.od3", od3, 32'hA2);
    chk("oor2.er3", W'(er3), 0);
    in_valid = 1'b0;
    advance();
    in_valid = 1'b1;
    out_ready = 1'b0;
    sel = 2'd1;
    advance();
    check_all("mid1");
    chk("mid1.od4", od4, 32'hA1);
    Rst = 1'b1;
    sel = 2'd0;
    advance();
    check_all("midrst");
    chk("midrst.ov4", W'(ov4), 0);
    chk("midrst.od4", od4, '0);
    chk("midrst.ir4", W'(ir4), 1);
    Rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    advance();
    check_all("midpost");
    chk("midpost.ov4", W'(ov4), 0);
    for (int i = 0; i < 400; i++) begin
      Rst = $urandom_range(0, 63) == 0;
      flush = $urandom_range(0, 15) == 0;
      in_valid = 1'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      sel = 2'($urandom);
      in_data = {$urandom, $urandom, $urandom, $urandom};
      advance();
      check_all("rnd");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_n_to_1_skid.md
# mux_n_to_1_skid

Parametrised N-way word multiplexer with a two-entry registered output stage and a valid/ready handshake, for operand/forwarding selection in the pipelined datapath. A word is selected from `NUM_IN` packed inputs on acceptance and held until the downstream stage consumes it. Stalls are absorbed by a skid entry without dropping data. The block also supports a synchronous pipeline flush and flags out-of-range selects.

## Interface
Parameters:
- `WIDTH`, 32, data word width in bits.
- `NUM_IN`, 4, number of input words; legal range is 2..16.
- `SEL_W`, derived localparam equal to `$clog2(NUM_IN)`; not overridable.

Ports:
- `Clk`  in  1  single clock; all state updates on rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `in_data`  in  `NUM_IN*WIDTH`  packed inputs; word i is `in_data[i*WIDTH +: WIDTH]`.
- `sel`  in  `SEL_W`  binary select; sampled only on accept.
- `in_valid`  in  1  upstream presents `in_data`/`sel`.
- `in_ready`  out  1  block can accept this cycle.
- `flush`  in  1  synchronous discard of all buffered words.
- `out_data`  out  `WIDTH`  selected word at the head of the buffer.
- `sel_err`  out  1  head word came from an out-of-range `sel`.
- `out_valid`  out  1  head word is valid.
- `out_ready`  in  1  downstream consumes the head this cycle.

## Operation
- Accept = `in_valid && in_ready`. Pop = `out_valid && out_ready`.
- On accept, the captured word is `in_data[sel]` when `sel < NUM_IN`.
- When `sel >= NUM_IN` (only possible when NUM_IN is not a power of 2), the captured word is 0 and its `sel_err` bit is 1.
- Storage: head register (drives the outputs) plus one skid register. Each entry holds {data, err}.
- States, encoded by occupancy:
  - EMPTY (0 entries).
  - ONE (head only).
  - TWO (head + skid).
- Transitions:
  - EMPTY: accept → ONE, head ← new word.
  - ONE:
    - accept and pop → ONE, head ← new word.
    - accept only → TWO, skid ← new word.
    - pop only → EMPTY.
  - TWO: pop → ONE, head ← skid. No accept is possible in TWO.
- `in_ready` = (state != TWO). It is a decode of registered state only and has no combinational path from `out_ready`.
- Flush:
  - Next state is EMPTY.
  - The word offered in the same cycle is discarded, even if `in_ready` was 1.
  - A pop in the same cycle is still counted as taken by downstream.
- Priority: `Rst` > `flush` > normal operation.
- Reset mid-operation discards all buffered words; no partial state survives.

## Timing
- Reset values:
  - state EMPTY.
  - `out_valid` 0.
  - `out_data` 0.
  - `sel_err` 0.
  - `in_ready` 1 from the first cycle after reset is sampled.
- Latency: a word accepted at edge k appears with `out_valid`=1 after edge k (1 cycle).
- Throughput: 1 word/cycle sustained while `out_ready` stays 1.
- While `out_valid && !out_ready`, `out_data` and `sel_err` are stable. `out_valid` cannot fall unless flush or Rst is asserted.
- When `out_ready` falls while in ONE with `in_valid`=1, the next word lands in skid. `in_ready` is 0 on the following cycle.
- In TWO with pop: the skid word appears on the outputs after the edge, and `in_ready` returns to 1 the same cycle.
- After a flush edge: `out_valid`=0 and `in_ready`=1. Data registers need not clear; `sel_err` qualifies only with `out_valid`.

## Structure
- Shared package `mux_pkg` holds:
  - the occupancy state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2);
  - the NUM_IN legal-range constants.
- Sub-module `mux_n_to_1` is the combinational N-way selector. It takes (`in_data`, `sel`) and produces (`word`, `err`), with the out-of-range → 0 rule.
- The top level contains only the state register, the head/skid registers and the handshake logic.

## Test plan
- **Reset:** Rst high for 2 cycles with random inputs → `out_valid`=0, `out_data`=0, `sel_err`=0; `in_ready`=1 after release.
- **Streaming:** NUM_IN=4, WIDTH=32, words 0xA0..0xA3, `sel` cycling 0,1,2,3, `in_valid`=`out_ready`=1 → outputs 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, 1-cycle latency.
- **Stall:**
  - With `out_ready`=0 for 3 cycles and `in_valid` held → two words buffered, `in_ready`=0 from the second cycle, head stable.
  - With `out_ready` then 1 → both words delivered in order, none lost or duplicated.
- **Out-of-range select:** NUM_IN=3, `sel`=3 → `out_data`=0, `sel_err`=1. The next word with `sel`=2 gives `sel_err`=0.
- **Flush in TWO:** flush asserted together with `in_valid`=1 → next cycle `out_valid`=0 and `in_ready`=1, and the flushed and concurrent words never appear.
- **Mid-stream reset:** Rst asserted while in ONE with accept pending → EMPTY next cycle, no word emitted.
